fft_frame_loader: RTL
=====================

FFT_FRAME_LOADER -- requirements
Module: fft_frame_loader

Interface
REQ-001 SHALL have parameter DATA_W, default 16: width of each real and imaginary sample component.
REQ-002 SHALL have parameter FFT_N, default 8: complex samples per frame; only 8 is supported.
REQ-003 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous and active-low.
REQ-005 SHALL have port in_valid, input, 1: an input sample is offered this cycle.
REQ-006 SHALL have port in_ready, output, 1: the loader can accept a sample this cycle.
REQ-007 SHALL have port in_real, input, DATA_W: real part of the offered sample, two's complement.
REQ-008 SHALL have port in_imag, input, DATA_W: imaginary part of the offered sample, two's complement.
REQ-009 SHALL have port in_sof, input, 1: the offered sample is slot 0 of a new frame.
REQ-010 SHALL have port frame_valid, output, 1: a complete 8-sample frame is presented.
REQ-011 SHALL have port frame_ready, input, 1: the downstream 8-point FFT consumes the frame.
REQ-012 SHALL have port frame_real, output, FFT_N*DATA_W: real parts, slot k in bits [DATA_W*k+DATA_W-1 : DATA_W*k].
REQ-013 SHALL have port frame_imag, output, FFT_N*DATA_W: imaginary parts, packed as in REQ-012.
REQ-014 SHALL have port drop_err, output, 1: one-cycle pulse when a partial frame is discarded.

Function
REQ-015 SHALL transfer an input sample only on a cycle where in_valid and in_ready are both high.
REQ-016 SHALL hold two frame banks (ping-pong), a write-bank select, a read-bank select, one full flag per bank, and a 3-bit slot counter.
REQ-017 SHALL store each accepted sample into slot = counter of the write bank, then increment the counter modulo 8.
REQ-018 SHALL, on acceptance at slot 7: set the write bank's full flag, toggle the write-bank select, and return the counter to 0.
REQ-019 SHALL drive in_ready = NOT full[write bank], combinationally from registered state only, never from in_valid.
REQ-020 SHALL drive frame_valid = full[read bank], asserting the cycle after slot 7 is accepted (1-cycle latency).
REQ-021 SHALL drive frame_real and frame_imag from the read bank, natural order (slot k = k-th sample), held stable while frame_valid is high.
REQ-022 SHALL, on frame_valid and frame_ready high, clear full[read bank] and toggle the read-bank select.
REQ-023 SHALL allow completion of one bank and release of the other in the same cycle, with both updates taking effect.
REQ-024 SHALL sustain 1 sample per cycle indefinitely when frame_ready is high within 8 cycles of each frame_valid.
REQ-025 SHALL, when both banks are full, hold in_ready low with no data lost until a frame is released.
REQ-026 SHALL, on accepted in_sof with counter 0, behave as a normal slot-0 write with no error.
REQ-027 SHALL, on accepted in_sof with counter nonzero: discard the partial frame, write the sample to slot 0, set the counter to 1, and pulse drop_err for exactly one cycle.
REQ-028 SHALL treat in_sof as optional: a sample accepted at counter 0 without in_sof starts a frame.
REQ-029 SHALL ignore in_real, in_imag and in_sof when no transfer occurs.

Reset
REQ-030 SHALL, while rst_n is low (asynchronously), force counter=0, both full flags=0, both bank selects=0, and all bank storage=0.
REQ-031 SHALL, as a result, output frame_valid=0, drop_err=0, frame_real=0, frame_imag=0, and in_ready=1.
REQ-032 SHALL, on reset mid-frame or with a frame pending, discard all buffered samples; no frame is presented after reset deassertion until 8 new samples are accepted.

Structure
REQ-033 SHALL take DATA_W, FFT_N, and counter width CNT_W=3 from the shared package fft_pkg, alongside the FFT datapath constants.
REQ-034 SHALL implement each bank as the sub-module fft_frame_bank (8 complex registers, write-enable plus slot index), instantiated twice.

Verification
REQ-035 SHALL cover: reset, then 8 back-to-back samples real=k, imag=-k (k=0..7) with frame_ready=1 -> frame_valid high for 1 cycle after the 8th, slot k real=k, imag=-k, in_ready always 1.
REQ-036 SHALL cover: frame_ready=0, 16 samples offered continuously -> in_ready low from cycle 17, exactly 16 accepted; frame_ready=1 then yields frame 0..7 followed by frame 8..15.
REQ-037 SHALL cover: 3 samples, then in_sof with real=100 -> drop_err one pulse; the next frame has slot0=100 followed by the 7 subsequent samples.
REQ-038 SHALL cover: rst_n low after 5 samples of frame 2 while frame 1 is pending -> all outputs at reset values, and 8 fresh samples produce a correct frame.
REQ-039 SHALL cover: frame completion and frame_ready in the same cycle on opposite banks -> no sample is lost or duplicated over 4 consecutive frames at full rate.
REQ-040 SHALL cover: extreme values 0x7FFF/0x8000 -> passed through bit-exact.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared constants for the FFT front end.
// Frame geometry and datapath widths used by loader and FFT core.
package fft_pkg;
  localparam int DATA_W = 16;
  localparam int FFT_N  = 8;
  localparam int CNT_W  = 3;
  localparam int LOG2_N = 3;
  localparam int TW_W   = 16;
  localparam int FRM_W  = FFT_N * DATA_W;

  typedef enum logic {
    BANK_A = 1'b0,
    BANK_B = 1'b1
  } bank_e;
endpackage

// File: rtl/fft_frame_loader_if.sv
// Sample-in / frame-out handshake bundle of the frame loader.
// master = producer/consumer side, slave = loader side.
interface fft_frame_loader_if #(
  parameter int DATA_W = 16,
  parameter int FFT_N  = 8
);
  logic                    in_valid;
  logic                    in_ready;
  logic [DATA_W-1:0]       in_real;
  logic [DATA_W-1:0]       in_imag;
  logic                    in_sof;
  logic                    frame_valid;
  logic                    frame_ready;
  logic [FFT_N*DATA_W-1:0] frame_real;
  logic [FFT_N*DATA_W-1:0] frame_imag;
  logic                    drop_err;

  modport master (
    output in_valid, in_real, in_imag, in_sof, frame_ready,
    input  in_ready, frame_valid, frame_real, frame_imag, drop_err
  );

  modport slave (
    input  in_valid, in_real, in_imag, in_sof, frame_ready,
    output in_ready, frame_valid, frame_real, frame_imag, drop_err
  );
endinterface

// File: rtl/fft_frame_bank.sv
// One frame bank: FFT_N complex registers, slot-indexed write.
// Read side presents the whole frame packed, slot k at lane k.
module fft_frame_bank
  import fft_pkg::*;
#(
  parameter int DW = fft_pkg::DATA_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               we,
  input  logic [CNT_W-1:0]   slot,
  input  logic [DW-1:0]      wr_real,
  input  logic [DW-1:0]      wr_imag,
  output logic [FFT_N*DW-1:0] rd_real,
  output logic [FFT_N*DW-1:0] rd_imag
);
  logic [DW-1:0] re_q [FFT_N];
  logic [DW-1:0] im_q [FFT_N];

  // sample storage, cleared on reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < FFT_N; k++) begin
        re_q[k] <= '0;
        im_q[k] <= '0;
      end
    end else if (we) begin
      re_q[slot] <= wr_real;
      im_q[slot] <= wr_imag;
    end
  end

  // pack slots into the frame bus in natural order
  always_comb begin
    rd_real = '0;
    rd_imag = '0;
    for (int k = 0; k < FFT_N; k++) begin
      rd_real[k*DW +: DW] = re_q[k];
      rd_imag[k*DW +: DW] = im_q[k];
    end
  end
endmodule

// File: rtl/fft_frame_loader.sv
// Ping-pong frame loader: collects FFT_N samples per bank and
// hands complete frames to the FFT while the other bank fills.
module fft_frame_loader
  import fft_pkg::*;
#(
  parameter int DATA_W = fft_pkg::DATA_W,
  parameter int FFT_N  = fft_pkg::FFT_N
) (
  input logic               clk,
  input logic               rst_n,
  fft_frame_loader_if.slave bus
);
  logic             wsel;
  logic             rsel;
  logic [1:0]       full;
  logic [CNT_W-1:0] cnt;
  logic             drop_q;
  logic             fire;
  logic             rel;
  logic             done;
  logic [CNT_W-1:0] slot;
  logic [FFT_N*DATA_W-1:0] re0, im0, re1, im1;

  assign bus.in_ready    = ~full[wsel];
  assign bus.frame_valid = full[rsel];
  assign bus.drop_err    = drop_q;

  assign fire = bus.in_valid & bus.in_ready;
  assign rel  = bus.frame_valid & bus.frame_ready;
  assign slot = bus.in_sof ? '0 : cnt;
  assign done = fire & (slot == CNT_W'(FFT_N - 1));

  assign bus.frame_real = rsel ? re1 : re0;
  assign bus.frame_imag = rsel ? im1 : im0;

  fft_frame_bank #(.DW(DATA_W)) u_bank0 (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (fire & (wsel == BANK_A)),
    .slot    (slot),
    .wr_real (bus.in_real),
    .wr_imag (bus.in_imag),
    .rd_real (re0),
    .rd_imag (im0)
  );

  fft_frame_bank #(.DW(DATA_W)) u_bank1 (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (fire & (wsel == BANK_B)),
    .slot    (slot),
    .wr_real (bus.in_real),
    .wr_imag (bus.in_imag),
    .rd_real (re1),
    .rd_imag (im1)
  );

  // bank bookkeeping; fill and release always hit different banks
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wsel   <= 1'b0;
      rsel   <= 1'b0;
      full   <= '0;
      cnt    <= '0;
      drop_q <= 1'b0;
    end else begin
      drop_q <= fire & bus.in_sof & (cnt != '0);
      if (fire)
        cnt <= slot + CNT_W'(1);
      if (rel) begin
        full[rsel] <= 1'b0;
        rsel       <= ~rsel;
      end
      if (done) begin
        full[wsel] <= 1'b1;
        wsel       <= ~wsel;
      end
    end
  end
endmodule
